// File: rtl/cpu6_io_pkg.sv
// ----------------------------------------------------------------------------
// cpu6_io_pkg
//   Shared definitions for the CPU6 memory-mapped I/O blocks.
//   - UART_BASE          : default address of the UART transmitter data register
//   - ST_* constants     : bit positions inside the UART status byte
//   - uart_tx_state_t    : transmitter FSM state encoding
//   - uart_status_byte() : assembles the status byte from its flag bits
// ----------------------------------------------------------------------------
package cpu6_io_pkg;

    localparam logic [15:0] UART_BASE = 16'hF200;

    localparam int ST_NOT_FULL = 0;
    localparam int ST_IDLE     = 1;
    localparam int ST_OVERRUN  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    function automatic logic [7:0] uart_status_byte(
        input logic not_full,
        input logic idle,
        input logic overrun
    );
        logic [7:0] status;
        status              = 8'h00;
        status[ST_NOT_FULL] = not_full;
        status[ST_IDLE]     = idle;
        status[ST_OVERRUN]  = overrun;
        return status;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with show-ahead read: rdata always presents the oldest
//   entry, so a consumer can pop and capture the data on the same edge.
//   Pointers carry one extra wrap bit (log2(DEPTH)+1 bits, modulo 2*DEPTH)
//   to tell full from empty.
//
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-low reset (empties the queue)
//     push   in   write wdata (ignored while full)
//     wdata  in   write data
//     pop    in   discard the head entry (ignored while empty)
//     rdata  out  head entry (valid while !empty)
//     full   out  queue holds DEPTH entries
//     empty  out  queue holds no entries
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Full/empty are evaluated before the edge, so a push while full is
    // dropped even if a pop frees a slot on that same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; resetting the pointers discards the contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    // Unregistered read: the transmitter loads its shift register on the
    // same edge that pops, so the head must be visible before that edge.
    assign rdata = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_tx_port.sv
// ----------------------------------------------------------------------------
// uart_tx_port
//   Memory-mapped 8N1 serial transmitter for the CPU6 bus. Bytes written to
//   BASE_ADDR are queued and shifted out LSB first on tx; BASE_ADDR+1 is the
//   status register (bit0 not full, bit1 idle, bit2 sticky overrun). Any
//   write to BASE_ADDR+1 clears the overrun flag.
//
//   Ports:
//     clock     in   system clock (rising edge)
//     reset     in   asynchronous active-low reset
//     address   in   [15:0] CPU address bus
//     write_en  in   CPU write strobe
//     data_in   in   [7:0] CPU write data
//     data_out  out  [7:0] status byte when address==BASE_ADDR+1, else 0
//     selected  out  address hits the data or status register
//     tx        out  serial line, idles high
//     busy      out  queue non-empty or frame in flight
// ----------------------------------------------------------------------------
module uart_tx_port
    import cpu6_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = UART_BASE,
    parameter int          CLOCK_DIV  = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;
    localparam int          CNT_W       = $clog2(CLOCK_DIV);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLOCK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Bus decode and overrun flag
    // ------------------------------------------------------------------
    logic wr_data;
    logic wr_status;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic [7:0] fifo_rdata;
    logic overrun_reg;
    logic overrun_next;

    assign wr_data   = write_en && (address == BASE_ADDR);
    assign wr_status = write_en && (address == STATUS_ADDR);
    assign fifo_push = wr_data && !fifo_full;

    // A dropped write outranks a clear on the same edge.
    always_comb begin
        overrun_next = overrun_reg;
        if (wr_data && fifo_full) begin
            overrun_next = 1'b1;
        end else if (wr_status) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (data_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Transmit FSM and baud counter
    // ------------------------------------------------------------------
    uart_tx_state_t   state_reg;
    uart_tx_state_t   state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic [2:0]       bit_idx_reg;
    logic [2:0]       bit_idx_next;
    logic             tx_reg;
    logic             tx_next;
    logic             bit_end;

    // The counter is loaded with CLOCK_DIV-1 when a bit starts, so reaching
    // zero marks the last clock of that bit.
    assign bit_end = (cnt_reg == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= TX_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= 8'h00;
            bit_idx_reg <= 3'd0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rdata;
                    tx_next    = 1'b0;
                    cnt_next   = CNT_LOAD;
                    state_next = TX_START;
                end
            end

            TX_START: begin
                if (bit_end) begin
                    tx_next      = shift_reg[0];
                    bit_idx_next = 3'd0;
                    cnt_next     = CNT_LOAD;
                    state_next   = TX_DATA;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            TX_DATA: begin
                if (bit_end) begin
                    cnt_next = CNT_LOAD;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = TX_STOP;
                    end else begin
                        // Next bit is shift_reg[1], i.e. the new shift[0].
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rdata;
                        tx_next    = 1'b0;
                        cnt_next   = CNT_LOAD;
                        state_next = TX_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = TX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            default: begin
                tx_next    = 1'b1;
                cnt_next   = '0;
                state_next = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic idle;

    assign idle     = fifo_empty && (state_reg == TX_IDLE);
    assign busy     = !idle;
    assign tx       = tx_reg;
    assign selected = (address == BASE_ADDR) || (address == STATUS_ADDR);
    assign data_out = (address == STATUS_ADDR)
                    ? uart_status_byte(!fifo_full, idle, overrun_reg)
                    : 8'h00;

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

    localparam int          CD    = 4;
    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hF200;
    localparam logic [15:0] STAT  = 16'hF201;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = STAT;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        selected;
    logic        tx;
    logic        busy;

    uart_tx_port #(
        .BASE_ADDR  (BASE),
        .CLOCK_DIV  (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .selected (selected),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte queue plus a frame that started at edge
    // m_start. The line level is derived from the elapsed clock count.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    logic [7:0] dec_q[$];
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovr = 1'b0;
    bit         m_full_pre;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            acc_q.delete();
            m_active = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            cyc = cyc + 1;
            m_full_pre = (mq.size() == DEPTH);
            if (m_active && (cyc - m_start) >= 10 * CD) m_active = 1'b0;
            if (!m_active && mq.size() != 0) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_start  = cyc;
            end
            if (write_en && address == BASE) begin
                if (m_full_pre) m_ovr = 1'b1;
                else begin
                    mq.push_back(data_in);
                    acc_q.push_back(data_in);
                end
            end else if (write_en && address == STAT) begin
                m_ovr = 1'b0;
            end
        end
    end

    function automatic logic exp_tx();
        int t;
        int b;
        if (!m_active) return 1'b1;
        t = cyc - m_start;
        b = t / CD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_dout();
        logic [7:0] s;
        s = 8'h00;
        if (address == STAT) begin
            s[0] = (mq.size() != DEPTH);
            s[1] = (mq.size() == 0) && !m_active;
            s[2] = m_ovr;
        end
        return s;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (reset) begin
            chk("cyc_tx", tx, exp_tx());
            chk("cyc_busy", busy, (mq.size() != 0) || m_active);
            chk("cyc_selected", selected, (address == BASE) || (address == STAT));
            chk("cyc_data_out", data_out, exp_dout());
        end
    end

    // ------------------------------------------------------------------
    // Independent line decoder: samples mid-bit, checks each frame against
    // the bytes the model accepted.
    // ------------------------------------------------------------------
    bit         d_on = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_sh = 8'h00;
    logic       d_prev = 1'b1;
    logic [7:0] d_exp;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            d_on   = 1'b0;
            d_prev = 1'b1;
        end else begin
            if (d_on) begin
                d_cnt++;
                if (d_cnt == CD / 2) chk("dec_start_mid", tx, 1'b0);
                if (d_cnt > CD && d_cnt < 9 * CD && (d_cnt % CD) == CD / 2)
                    d_sh[d_cnt / CD - 1] = tx;
                if (d_cnt == 9 * CD + CD / 2) begin
                    chk("dec_stop_bit", tx, 1'b1);
                    chk("dec_frame_expected", acc_q.size() != 0, 1'b1);
                    if (acc_q.size() != 0) begin
                        d_exp = acc_q.pop_front();
                        chk("dec_byte_vs_model", d_sh, d_exp);
                    end
                    dec_q.push_back(d_sh);
                    d_on = 1'b0;
                end
            end else if (d_prev && !tx) begin
                d_on  = 1'b1;
                d_cnt = 0;
            end
            d_prev = tx;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output int k);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        k        = cyc;
        write_en = 1'b0;
        address  = 16'h0000;
    endtask

    task automatic goto_edge(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic read_status(input string name, input logic [7:0] exp);
        address = STAT;
        #1;
        chk(name, data_out, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic chk_dec(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, dec_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dec_q.size(); i++)
            chk(name, dec_q[i], exp[i]);
        dec_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int k;
        int k2;
        logic [7:0] lit;
        logic [7:0] exp_bytes[$];

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_status", data_out, 8'h03);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);

        // 0x55 frame timing
        lit = 8'h55;
        bus_write(BASE, lit, k);
        chk("t1_busy_after_k", busy, 1'b1);
        chk("t1_tx_after_k", tx, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            goto_edge(k + j);
            chk("t1_start_low", tx, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            goto_edge(k + 5 + 4 * i + 1);
            chk("t1_data_bit", tx, lit[i]);
        end
        goto_edge(k + 37);
        chk("t1_stop_high", tx, 1'b1);
        goto_edge(k + 40);
        chk("t1_busy_k40", busy, 1'b1);
        goto_edge(k + 41);
        chk("t1_busy_k41", busy, 1'b0);
        exp_bytes = '{8'h55};
        chk_dec("t1_byte", exp_bytes);

        // Back-to-back frames
        bus_write(BASE, 8'hA3, k2);
        bus_write(BASE, 8'h0F, k);
        for (int j = 37; j <= 40; j++) begin
            goto_edge(k2 + j);
            chk("t2_stop1_high", tx, 1'b1);
        end
        goto_edge(k2 + 41);
        chk("t2_start2_no_gap", tx, 1'b0);
        wait_idle(500);
        exp_bytes = '{8'hA3, 8'h0F};
        chk_dec("t2_byte", exp_bytes);
        read_status("t2_status", 8'h03);

        // Nine consecutive writes while idle: first pop frees a slot
        for (int i = 0; i < 9; i++) bus_write(BASE, 8'(i), k);
        chk("t3_queued", mq.size(), 8);
        read_status("t3_status_full", 8'h00);
        wait_idle(1000);
        exp_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        chk_dec("t3_byte", exp_bytes);
        read_status("t3_status_drained", 8'h03);

        // Overrun with transmitter held busy
        bus_write(BASE, 8'h11, k);
        goto_edge(k + 2);
        for (int i = 0; i < 9; i++) bus_write(BASE, 8'(8'h20 + i), k2);
        read_status("t4_status_overrun", 8'h04);
        bus_write(STAT, 8'hFF, k2);
        read_status("t4_status_cleared", 8'h00);
        wait_idle(1000);
        exp_bytes = '{8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        chk_dec("t4_byte", exp_bytes);
        read_status("t4_status_drained", 8'h03);

        // Reset in the middle of a data bit
        bus_write(BASE, 8'h5A, k);
        bus_write(BASE, 8'h33, k2);
        bus_write(BASE, 8'h44, k2);
        goto_edge(k + 12);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_tx_async_high", tx, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_busy_after_reset", busy, 1'b0);
        read_status("t5_status", 8'h03);
        k2 = cyc;
        goto_edge(k2 + 100);
        chk("t5_no_frames", dec_q.size(), 0);
        chk("t5_tx_idle", tx, 1'b1);
        dec_q.delete();

        // Writes to unmapped addresses
        bus_write(16'hF202, 8'h41, k);
        bus_write(16'h0200, 8'h41, k);
        address = 16'hF202;
        #1;
        chk("t6_sel_f202", selected, 1'b0);
        chk("t6_dout_f202", data_out, 8'h00);
        address = 16'h0200;
        #1;
        chk("t6_sel_0200", selected, 1'b0);
        chk("t6_dout_0200", data_out, 8'h00);
        address = BASE;
        #1;
        chk("t6_sel_base", selected, 1'b1);
        chk("t6_dout_base", data_out, 8'h00);
        goto_edge(k + 50);
        chk("t6_tx_high", tx, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_no_frames", dec_q.size(), 0);

        // Randomised traffic: alternating heavy and light write rates
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 100; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                write_en = (seg % 2 == 0) ? (r < 40) : (r < 3);
                case ($urandom_range(0, 3))
                    0, 1:    address = BASE;
                    2:       address = STAT;
                    default: address = 16'($urandom);
                endcase
                data_in = 8'($urandom);
                @(posedge clock);
                #1;
            end
        end
        write_en = 1'b0;
        address  = STAT;
        wait_idle(2000);
        chk("rand_all_sent", acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
